// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the BCD-to-binary converter.
// The master drives the input and consumes the result; the slave is the converter.
interface bcd_to_bin_seq_if #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;
   logic                  busy;

   modport master (
      output in_valid,
      output bcd_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  bin_out,
      input  err,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  bcd_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output bin_out,
      output err,
      output busy
   );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// One right shift plus per-digit correction per cycle, BIN_W cycles total.
module bcd_to_bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input logic             clk,
   input logic             reset,
   bcd_to_bin_seq_if.slave bus
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [BW-1:0]    bcd_sr;
   logic [BW-1:0]    nxt_bcd;
   logic [BIN_W-1:0] bin_sr;
   logic [BIN_W-1:0] nxt_bin;
   logic [CW-1:0]    cnt;
   logic             bad;
   logic             last;

   // Digits at 8 or above after the shift held 10+ before it: undo by 3.
   always_comb begin
      nxt_bin = {bcd_sr[0], bin_sr[BIN_W-1:1]};
      nxt_bcd = bcd_sr >> 1;
      for (int d = 0; d < DIGITS; d++) begin
         if (nxt_bcd[4*d+3])
            nxt_bcd[4*d +: 4] = nxt_bcd[4*d +: 4] - 4'd3;
      end
   end

   always_comb begin
      bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bus.bcd_in[4*d +: 4] > 4'd9)
            bad = 1'b1;
      end
   end

   assign last = (cnt == CW'(BIN_W - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         bcd_sr        <= '0;
         bin_sr        <= '0;
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.bin_out   <= '0;
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.in_ready  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  bcd_sr       <= bus.bcd_in;
                  bin_sr       <= '0;
                  cnt          <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  if (bad) begin
                     state       <= DONE;
                     bus.err     <= 1'b1;
                     bus.bin_out <= '0;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               bcd_sr <= nxt_bcd;
               bin_sr <= nxt_bin;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  state         <= DONE;
                  bus.bin_out   <= nxt_bin;
                  bus.err       <= 1'b0;
                  bus.out_valid <= 1'b1;
               end
            end
            DONE: begin
               // The error path arrives with out_valid low; raise it here.
               if (bus.out_valid && bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end else begin
                  bus.out_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
